// File: rtl/uart_rx_if.sv
// Serial receive bundle: oversampling strobe and line in, byte and status out.
interface uart_rx_if;
   logic       baud_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_busy;
   logic       rx_frame_err;

   // The side that owns the line and the tick generator.
   modport master (
      output baud_tick,
      output rx,
      input  rx_data,
      input  rx_done,
      input  rx_busy,
      input  rx_frame_err
   );

   // The receiver itself.
   modport slave (
      input  baud_tick,
      input  rx,
      output rx_data,
      output rx_done,
      output rx_busy,
      output rx_frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver driven by an OVS-times-baud tick strobe.
// The start bit is re-checked at mid-bit, each data bit is sampled at
// mid-bit, and the frame is closed at mid-stop-bit so a following frame
// may start with no idle gap.
module uart_rx #(
   parameter int OVS = 8
) (
   input  logic clk,
   input  logic reset,
   uart_rx_if.slave bus
);

   localparam int CW = $clog2(OVS);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic [1:0]    sync_reg;
   logic          rx_s;

   state_t        state_reg, state_next;
   logic [CW-1:0] tick_cnt_reg, tick_cnt_next;
   logic [2:0]    bit_idx_reg, bit_idx_next;
   logic [7:0]    sh_reg, sh_next;
   logic          armed_reg, armed_next;
   logic [7:0]    rx_data_reg, rx_data_next;
   logic          rx_done_reg, rx_done_next;
   logic          rx_busy_reg, rx_busy_next;
   logic          rx_frame_err_reg, rx_frame_err_next;

   // Two-stage synchronizer; both stages reset to the idle (high) level
   // so a reset never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], bus.rx};
      end
   end

   assign rx_s = sync_reg[1];

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= IDLE;
         tick_cnt_reg     <= '0;
         bit_idx_reg      <= '0;
         sh_reg           <= '0;
         armed_reg        <= 1'b1;
         rx_data_reg      <= 8'h00;
         rx_done_reg      <= 1'b0;
         rx_busy_reg      <= 1'b0;
         rx_frame_err_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         tick_cnt_reg     <= tick_cnt_next;
         bit_idx_reg      <= bit_idx_next;
         sh_reg           <= sh_next;
         armed_reg        <= armed_next;
         rx_data_reg      <= rx_data_next;
         rx_done_reg      <= rx_done_next;
         rx_busy_reg      <= rx_busy_next;
         rx_frame_err_reg <= rx_frame_err_next;
      end
   end

   // Next-state logic: everything advances only on a tick; the two status
   // pulses fall back to zero on every clk so they last exactly one cycle.
   always_comb begin
      state_next        = state_reg;
      tick_cnt_next     = tick_cnt_reg;
      bit_idx_next      = bit_idx_reg;
      sh_next           = sh_reg;
      armed_next        = armed_reg;
      rx_data_next      = rx_data_reg;
      rx_busy_next      = rx_busy_reg;
      rx_done_next      = 1'b0;
      rx_frame_err_next = 1'b0;

      if (bus.baud_tick) begin
         case (state_reg)
            IDLE: begin
               // After a framing error the line must be seen high once
               // before a new start is accepted, so a break reports once.
               if (rx_s) begin
                  armed_next = 1'b1;
               end else if (armed_reg) begin
                  state_next    = START;
                  tick_cnt_next = '0;
                  rx_busy_next  = 1'b1;
               end
            end

            START: begin
               if (tick_cnt_reg == HALF_LAST) begin
                  if (!rx_s) begin
                     state_next    = DATA;
                     tick_cnt_next = '0;
                     bit_idx_next  = '0;
                  end else begin
                     // Glitch shorter than half a bit: abandon quietly.
                     state_next   = IDLE;
                     rx_busy_next = 1'b0;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end

            DATA: begin
               if (tick_cnt_reg == FULL_LAST) begin
                  sh_next       = {rx_s, sh_reg[7:1]};
                  tick_cnt_next = '0;
                  if (bit_idx_reg == 3'd7) begin
                     state_next = STOP;
                  end else begin
                     bit_idx_next = bit_idx_reg + 1'b1;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end

            STOP: begin
               if (tick_cnt_reg == FULL_LAST) begin
                  state_next    = IDLE;
                  tick_cnt_next = '0;
                  rx_busy_next  = 1'b0;
                  if (rx_s) begin
                     rx_data_next = sh_reg;
                     rx_done_next = 1'b1;
                  end else begin
                     rx_frame_err_next = 1'b1;
                     armed_next        = 1'b0;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign bus.rx_data      = rx_data_reg;
   assign bus.rx_done      = rx_done_reg;
   assign bus.rx_busy      = rx_busy_reg;
   assign bus.rx_frame_err = rx_frame_err_reg;

endmodule
